// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak theta engine: state encoding,
// mod-5 lane-coordinate stepping and a width-generic bit rotation.
package keccak_pkg;

  localparam int NLANES = 25;

  typedef enum logic [2:0] {
    LOAD,
    PARITY,
    DCALC,
    APPLY,
    OUT
  } state_t;

  function automatic logic [2:0] mod5_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] mod5_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

  // Rotates the low w bits of v left by n (mod w); bits at and above w are zero.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int n, input int w);
    logic [63:0] r;
    int s;
    r = '0;
    s = n % w;
    if (s < 0) s = s + w;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[(i + s) % w] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_theta_blk_if.sv
// Lane stream between the absorb front-end, the theta engine and the
// downstream rho/pi/chi stages; master drives lanes in, slave is the engine.
interface keccak_theta_blk_if #(
  parameter int LANE_W = 64
);
  logic              theta_en;
  logic              pushin;
  logic              firstin;
  logic [LANE_W-1:0] din;
  logic              stopin;
  logic              pushout;
  logic              firstout;
  logic [LANE_W-1:0] dout;
  logic              stopout;

  modport master (
    output theta_en, pushin, firstin, din, stopout,
    input  stopin, pushout, firstout, dout
  );

  modport slave (
    input  theta_en, pushin, firstin, din, stopout,
    output stopin, pushout, firstout, dout
  );
endinterface

// File: rtl/keccak_lane_ram.sv
// 25-entry lane register file addressed by (x,y): asynchronous read,
// synchronous write. Contents are not reset.
module keccak_lane_ram
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [2:0]        wx,
  input  logic [2:0]        wy,
  input  logic [LANE_W-1:0] wdata,
  input  logic [2:0]        rx,
  input  logic [2:0]        ry,
  output logic [LANE_W-1:0] rdata
);
  logic [LANE_W-1:0] mem [NLANES];
  logic [4:0] widx, ridx;

  assign widx  = {2'b00, wx} + {2'b00, wy} * 5'd5;
  assign ridx  = {2'b00, rx} + {2'b00, ry} * 5'd5;
  assign rdata = mem[ridx];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end
endmodule

// File: rtl/keccak_theta_blk.sv
// Keccak theta step over a streamed 25-lane state: load, column parity,
// D vector, in-place apply, then stream out with backpressure.
module keccak_theta_blk
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int ROT_D  = 1
) (
  input logic                clk,
  input logic                rst,
  keccak_theta_blk_if.slave  bus
);
  state_t            state_q;
  logic [2:0]        x_q, y_q, nx, ny;
  logic              theta_q;
  logic              stopin_q, pushout_q, firstout_q;
  logic [LANE_W-1:0] dout_q;
  logic [LANE_W-1:0] c_q [5];
  logic [LANE_W-1:0] d_q [5];

  logic              we;
  logic [2:0]        wx, wy, rx, ry;
  logic [LANE_W-1:0] wdata, rdata;
  logic              accept, advance, first_slot, last_lane;

  assign accept     = bus.pushin && !stopin_q;
  assign advance    = pushout_q && !bus.stopout;
  assign first_slot = (x_q == 3'd0) && (y_q == 3'd0);
  assign last_lane  = (x_q == 3'd4) && (y_q == 3'd4);
  // Raster step; wraps (4,4) -> (0,0) so no explicit clear is needed.
  assign nx         = mod5_inc(x_q);
  assign ny         = (x_q == 3'd4) ? mod5_inc(y_q) : y_q;

  assign bus.stopin   = stopin_q;
  assign bus.pushout  = pushout_q;
  assign bus.firstout = firstout_q;
  assign bus.dout     = dout_q;

  keccak_lane_ram #(.LANE_W(LANE_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .wx    (wx),
    .wy    (wy),
    .wdata (wdata),
    .rx    (rx),
    .ry    (ry),
    .rdata (rdata)
  );

  always_comb begin
    we    = 1'b0;
    wx    = x_q;
    wy    = y_q;
    wdata = bus.din;
    rx    = x_q;
    ry    = y_q;
    case (state_q)
      LOAD: begin
        // A lane without firstin at slot 0 is dropped; firstin always lands at slot 0.
        if (accept && (bus.firstin || !first_slot)) begin
          we = 1'b1;
          if (bus.firstin) begin
            wx = 3'd0;
            wy = 3'd0;
          end
        end
      end
      APPLY: begin
        we    = 1'b1;
        wdata = rdata ^ d_q[x_q];
      end
      OUT: begin
        // Prefetch the next lane so dout can update on the advancing edge.
        rx = nx;
        ry = ny;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      x_q        <= 3'd0;
      y_q        <= 3'd0;
      stopin_q   <= 1'b0;
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      case (state_q)
        // Load: lanes arrive in raster order
        LOAD: begin
          if (accept) begin
            if (bus.firstin) begin
              x_q <= 3'd1;
              y_q <= 3'd0;
            end else if (!first_slot) begin
              x_q <= nx;
              y_q <= ny;
              if (last_lane) begin
                state_q  <= PARITY;
                stopin_q <= 1'b1;
              end
            end
          end
        end
        // Parity: one lane folded into C per cycle
        PARITY: begin
          x_q <= nx;
          y_q <= ny;
          if (last_lane) state_q <= DCALC;
        end
        // D vector: one column per cycle
        DCALC: begin
          x_q <= nx;
          if (x_q == 3'd4) state_q <= APPLY;
        end
        // Apply: written back in place; lane 0 result preloads dout
        APPLY: begin
          x_q <= nx;
          y_q <= ny;
          if (first_slot) dout_q <= wdata;
          if (last_lane) begin
            state_q    <= OUT;
            pushout_q  <= 1'b1;
            firstout_q <= 1'b1;
          end
        end
        // Out: hold lane until downstream takes it
        OUT: begin
          if (advance) begin
            x_q        <= nx;
            y_q        <= ny;
            firstout_q <= 1'b0;
            dout_q     <= rdata;
            if (last_lane) begin
              state_q   <= LOAD;
              pushout_q <= 1'b0;
              stopin_q  <= 1'b0;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Datapath registers carry no reset; C is cleared throughout LOAD.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && accept && bus.firstin) theta_q <= bus.theta_en;
    if (state_q == LOAD) begin
      for (int i = 0; i < 5; i++) c_q[i] <= '0;
    end
    if (state_q == PARITY) c_q[x_q] <= c_q[x_q] ^ rdata;
    if (state_q == DCALC) begin
      d_q[x_q] <= theta_q
        ? (c_q[mod5_dec(x_q)] ^ LANE_W'(rotl(64'(c_q[mod5_inc(x_q)]), ROT_D, LANE_W)))
        : '0;
    end
  end
endmodule

// File: tb/tb_keccak_theta_blk.sv
// Directed bench for keccak_theta_blk: a 64-bit and an 8-bit instance, expected
// lanes queued at stimulus time and checked as each lane is taken downstream.
module tb_keccak_theta_blk;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_theta_blk_if #(.LANE_W(64)) b64 ();
  keccak_theta_blk_if #(.LANE_W(8))  b8 ();

  keccak_theta_blk #(.LANE_W(64), .ROT_D(1)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));
  keccak_theta_blk #(.LANE_W(8),  .ROT_D(1)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [64:0] q64[$];
  logic [64:0] q8[$];
  logic [63:0] lanes [25];
  logic [63:0] expv  [25];
  int          adv64 = 0;
  logic        stall64 = 1'b0, stall8 = 1'b0;
  logic [63:0] hold64, hold8;
  logic        holdf64, holdf8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Straight Keccak theta for ROT_D=1 on w-bit lanes.
  function automatic void theta_ref(input logic [63:0] a[25], input int w, input bit en,
                                    output logic [63:0] r[25]);
    logic [63:0] m, c[5], d[5], t;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ (a[x + 5*y] & m);
    end
    for (int x = 0; x < 5; x++) begin
      t    = c[(x + 1) % 5];
      d[x] = en ? (c[(x + 4) % 5] ^ (((t << 1) | (t >> (w - 1))) & m)) : 64'd0;
    end
    for (int i = 0; i < 25; i++) r[i] = (a[i] ^ d[i % 5]) & m;
  endfunction

  task automatic mon64();
    if (rst) begin
      stall64 = 1'b0;
    end else begin
      if (stall64 && b64.pushout) begin
        check("hold_dout64", b64.dout, hold64);
        check("hold_first64", 64'(b64.firstout), 64'(holdf64));
      end
      if (b64.pushout) begin
        check("stopin_busy64", 64'(b64.stopin), 64'd1);
        if (!b64.stopout) begin
          check("lane_expected64", 64'(q64.size() > 0), 64'd1);
          if (q64.size() > 0) begin
            check("dout64", b64.dout, q64[0][63:0]);
            check("firstout64", 64'(b64.firstout), 64'(q64[0][64]));
            void'(q64.pop_front());
            adv64++;
          end
        end
      end
      stall64 = b64.pushout && b64.stopout;
      hold64  = b64.dout;
      holdf64 = b64.firstout;
    end
  endtask

  task automatic mon8();
    if (rst) begin
      stall8 = 1'b0;
    end else begin
      if (stall8 && b8.pushout) check("hold_dout8", 64'(b8.dout), hold8);
      if (b8.pushout && !b8.stopout) begin
        check("lane_expected8", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          check("dout8", 64'(b8.dout), q8[0][63:0]);
          check("firstout8", 64'(b8.firstout), 64'(q8[0][64]));
          void'(q8.pop_front());
        end
      end
      stall8 = b8.pushout && b8.stopout;
      hold8  = 64'(b8.dout);
      holdf8 = b8.firstout;
    end
  endtask

  always @(negedge clk) begin
    mon64();
    mon8();
  end

  task automatic wait_ready(input bit is8);
    int k;
    k = 0;
    @(negedge clk);
    while ((is8 ? b8.stopin : b64.stopin) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check("ready_timeout", 64'd1, 64'd0);
  endtask

  // Sends lanes[0..nl-1] (lane 0 with firstin); queues expv when do_push.
  task automatic send(input bit is8, input bit en, input int nl, input bit do_push);
    if (do_push) begin
      for (int i = 0; i < 25; i++) begin
        if (is8) q8.push_back({i == 0, expv[i]});
        else     q64.push_back({i == 0, expv[i]});
      end
    end
    for (int i = 0; i < nl; i++) begin
      if (is8) begin
        b8.pushin = 1'b1; b8.firstin = (i == 0); b8.din = lanes[i][7:0]; b8.theta_en = en;
      end else begin
        b64.pushin = 1'b1; b64.firstin = (i == 0); b64.din = lanes[i]; b64.theta_en = en;
      end
      wait_ready(is8);
      @(posedge clk); #1;
    end
    b8.pushin = 1'b0;  b8.firstin = 1'b0;
    b64.pushin = 1'b0; b64.firstin = 1'b0;
  endtask

  task automatic drain(input bit is8);
    int k;
    k = 0;
    while (((is8 ? q8.size() : q64.size()) != 0 || (is8 ? b8.pushout : b64.pushout)) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(is8 ? "drain8" : "drain64", 64'(k < 3000), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom(), $urandom()};
  endtask

  initial begin
    int n, k, held;
    rst = 1'b1;
    b64.theta_en = 1'b1; b64.pushin = 1'b0; b64.firstin = 1'b0; b64.din = '0; b64.stopout = 1'b0;
    b8.theta_en  = 1'b1; b8.pushin  = 1'b0; b8.firstin  = 1'b0; b8.din  = '0; b8.stopout  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stopin", 64'(b64.stopin), 64'd0);
    check("rst_pushout", 64'(b64.pushout), 64'd0);
    check("rst_firstout", 64'(b64.firstout), 64'd0);
    check("rst_dout", b64.dout, 64'd0);
    rst = 1'b0;

    // All-zero state, theta on, with latency measurement
    for (int i = 0; i < 25; i++) begin lanes[i] = '0; expv[i] = '0; end
    send(1'b0, 1'b1, 25, 1'b1);
    n = 0;
    while (!b64.pushout && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd55);
    drain(1'b0);

    // Single bit in lane (0,0), 64-bit lanes
    for (int i = 0; i < 25; i++) begin lanes[i] = '0; expv[i] = '0; end
    lanes[0] = 64'h1;
    expv[0]  = 64'h1;
    for (int y = 0; y < 5; y++) begin
      expv[1 + 5*y] = 64'h1;
      expv[4 + 5*y] = 64'h2;
    end
    send(1'b0, 1'b1, 25, 1'b1);
    drain(1'b0);

    // Top bit in lane (0,0), 8-bit lanes: rotation wraps into bit 0
    for (int i = 0; i < 25; i++) begin lanes[i] = '0; expv[i] = '0; end
    lanes[0] = 64'h80;
    expv[0]  = 64'h80;
    for (int y = 0; y < 5; y++) begin
      expv[1 + 5*y] = 64'h80;
      expv[4 + 5*y] = 64'h01;
    end
    send(1'b1, 1'b1, 25, 1'b1);
    drain(1'b1);

    // Stray lane without firstin at slot 0, then a bypassed random state
    b64.pushin = 1'b1; b64.firstin = 1'b0; b64.din = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    b64.pushin = 1'b0;
    fill_random();
    for (int i = 0; i < 25; i++) expv[i] = lanes[i];
    send(1'b0, 1'b0, 25, 1'b1);
    drain(1'b0);

    // Resync: 7 junk lanes (bypass), then a full theta state restarting at lane 0
    fill_random();
    send(1'b0, 1'b0, 7, 1'b0);
    fill_random();
    theta_ref(lanes, 64, 1'b1, expv);
    send(1'b0, 1'b1, 25, 1'b1);
    drain(1'b0);

    // Backpressure: 10-cycle stall at lane 3 plus random stopout
    fill_random();
    theta_ref(lanes, 64, 1'b1, expv);
    adv64 = 0;
    send(1'b0, 1'b1, 25, 1'b1);
    held = 0;
    k = 0;
    while (q64.size() != 0 && k < 3000) begin
      if (adv64 == 3 && b64.pushout && held < 10) begin
        b64.stopout = 1'b1;
        held++;
      end else begin
        b64.stopout = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      k++;
    end
    b64.stopout = 1'b0;
    check("stall_drain", 64'(k < 3000), 64'd1);
    drain(1'b0);

    // Random 8-bit state with theta
    fill_random();
    theta_ref(lanes, 8, 1'b1, expv);
    send(1'b1, 1'b1, 25, 1'b1);
    drain(1'b1);

    // Reset in the middle of APPLY, then a clean zero state
    fill_random();
    send(1'b0, 1'b1, 25, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("apply_rst_stopin", 64'(b64.stopin), 64'd0);
    check("apply_rst_pushout", 64'(b64.pushout), 64'd0);
    for (int i = 0; i < 25; i++) begin lanes[i] = '0; expv[i] = '0; end
    send(1'b0, 1'b1, 25, 1'b1);
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
